// File: rtl/prbs_amp_offset_scaler.sv
// Gain/offset scaler for the shaped PRBS stream: 3-stage datapath with saturation and boundary-aligned config commit.
// Optional build macro PRBS_SCALER_ROUND_EN selects round-half-up in the gain stage (default: truncation).
module prbs_amp_offset_scaler #(
    parameter int PIPE_LAT       = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        dac_clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        bit_boundary,
    input  logic        out_en,
    input  logic [15:0] cfg_amp,
    input  logic [15:0] cfg_offset,
    input  logic        cfg_update,
    input  logic        sat_clr,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        cfg_pending,
    output logic        cfg_applied,
    output logic        sat_flag,
    output logic [15:0] sat_count
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;

    if (PIPE_LAT != 3) begin : g_lat_chk
        $error("prbs_amp_offset_scaler supports only PIPE_LAT = 3");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_tmo_chk
        $error("prbs_amp_offset_scaler TIMEOUT_CYCLES out of range 2..65535");
    end

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2
    } cfg_state_t;

    cfg_state_t state, state_nxt;
    logic [15:0] tmo_cnt;
    logic [COEF_W-1:0] shadow_amp, active_amp;
    logic signed [DATA_W-1:0] shadow_off, active_off;

    logic signed [DATA_W-1:0] s_p0, off_p0;
    logic [COEF_W-1:0]        amp_p0;
    logic                     vld_p0;
    logic signed [17:0]       q_p1;
    logic signed [DATA_W-1:0] off_p1;
    logic                     vld_p1;

    logic signed [32:0] p_c;
    logic signed [18:0] r_c;
    logic               sat_now;

    function automatic logic signed [17:0] gain_shift(input logic signed [32:0] p);
        logic signed [32:0] pr;
`ifdef PRBS_SCALER_ROUND_EN
        pr = p + 33'sd16384;
`else
        pr = p;
`endif
        return pr[32:15];
    endfunction

    function automatic logic clip_hit(input logic signed [18:0] r);
        return (r > 19'sd32767) || (r < -19'sd32768);
    endfunction

    function automatic logic signed [15:0] clip16(input logic signed [18:0] r);
        if (r > 19'sd32767)
            return 16'sh7FFF;
        else if (r < -19'sd32768)
            return 16'sh8000;
        else
            return r[15:0];
    endfunction

    // Config FSM: shadow captures on every cfg_update, active only moves in APPLY
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_update) state_nxt = WAIT;
            WAIT: begin
                if (cfg_update)
                    state_nxt = WAIT;
                else if (bit_boundary || tmo_cnt == TMO_LAST)
                    state_nxt = APPLY;
            end
            APPLY:   state_nxt = cfg_update ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            shadow_amp <= 16'h8000;
            shadow_off <= '0;
            active_amp <= 16'h8000;
            active_off <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_update) begin
                shadow_amp <= cfg_amp;
                shadow_off <= cfg_offset;
                tmo_cnt    <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (state == APPLY) begin
                active_amp <= shadow_amp;
                active_off <= shadow_off;
            end
        end
    end

    assign cfg_pending = (state == WAIT);
    assign cfg_applied = (state == APPLY);

    // Stage 1: recentre sample and bind it to the active amp/offset pair
    always_ff @(posedge dac_clk) begin
        s_p0   <= $signed(in_data ^ 16'h8000);
        amp_p0 <= active_amp;
        off_p0 <= active_off;
    end

    // Stage 2: Q1.15 gain
    assign p_c = s_p0 * $signed({1'b0, amp_p0});

    always_ff @(posedge dac_clk) begin
        q_p1   <= gain_shift(p_c);
        off_p1 <= off_p0;
    end

    // Stage 3: offset, clamp, midscale force and saturation accounting
    assign r_c     = $signed({q_p1[17], q_p1}) + $signed({{3{off_p1[15]}}, off_p1});
    assign sat_now = vld_p1 && clip_hit(r_c);

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h8000;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
            if (vld_p1)
                out_data <= out_en ? (clip16(r_c) ^ 16'h8000) : 16'h8000;
            if (sat_clr) begin
                sat_flag  <= sat_now;
                sat_count <= sat_now ? 16'd1 : 16'd0;
            end else if (sat_now) begin
                sat_flag <= 1'b1;
                if (sat_count != 16'hFFFF)
                    sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_amp_offset_scaler.sv
// Directed bench for prbs_amp_offset_scaler with TIMEOUT_CYCLES = 16; expected values computed by hand.
module tb_prbs_amp_offset_scaler;

    logic        dac_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        bit_boundary;
    logic        out_en;
    logic [15:0] cfg_amp;
    logic [15:0] cfg_offset;
    logic        cfg_update;
    logic        sat_clr;
    logic        out_valid;
    logic [15:0] out_data;
    logic        cfg_pending;
    logic        cfg_applied;
    logic        sat_flag;
    logic [15:0] sat_count;

    int errors = 0;
    int checks = 0;

`ifdef PRBS_SCALER_ROUND_EN
    localparam logic [15:0] ROUND_EXP = 16'h8001;
`else
    localparam logic [15:0] ROUND_EXP = 16'h8000;
`endif

    prbs_amp_offset_scaler #(.PIPE_LAT(3), .TIMEOUT_CYCLES(16)) dut (
        .dac_clk     (dac_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .bit_boundary(bit_boundary),
        .out_en      (out_en),
        .cfg_amp     (cfg_amp),
        .cfg_offset  (cfg_offset),
        .cfg_update  (cfg_update),
        .sat_clr     (sat_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .cfg_pending (cfg_pending),
        .cfg_applied (cfg_applied),
        .sat_flag    (sat_flag),
        .sat_count   (sat_count)
    );

    always #5 dac_clk = ~dac_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge dac_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // capture, boundary commit, then step past the APPLY cycle
    task automatic commit(input logic [15:0] amp, input logic [15:0] off, input string tag);
        cfg_amp    = amp;
        cfg_offset = off;
        cfg_update = 1'b1;
        tick(1);
        cfg_update   = 1'b0;
        bit_boundary = 1'b1;
        tick(1);
        bit_boundary = 1'b0;
        chk(tag, {15'd0, cfg_applied}, 16'd1);
        tick(1);
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 16'h8000;
        bit_boundary = 1'b0;
        out_en       = 1'b1;
        cfg_amp      = 16'h8000;
        cfg_offset   = 16'h0000;
        cfg_update   = 1'b0;
        sat_clr      = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("rst_out_valid",   {15'd0, out_valid},   16'd0);
        chk("rst_out_data",    out_data,             16'h8000);
        chk("rst_cfg_pending", {15'd0, cfg_pending}, 16'd0);
        chk("rst_cfg_applied", {15'd0, cfg_applied}, 16'd0);
        chk("rst_sat_flag",    {15'd0, sat_flag},    16'd0);
        chk("rst_sat_count",   sat_count,            16'd0);

        // unity passthrough and latency
        in_valid = 1'b1;
        in_data  = 16'hC000;
        tick(2);
        chk("lat_not_yet", {15'd0, out_valid}, 16'd0);
        tick(1);
        chk("lat_valid",   {15'd0, out_valid}, 16'd1);
        chk("unity_data",  out_data,           16'hC000);
        chk("unity_nosat", {15'd0, sat_flag},  16'd0);

        // staged gain waits for a boundary
        cfg_amp    = 16'h4000;
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        chk("pend_set", {15'd0, cfg_pending}, 16'd1);
        tick(3);
        chk("pend_hold_data", out_data,           16'hC000);
        chk("pend_still",     {15'd0, cfg_pending}, 16'd1);
        bit_boundary = 1'b1;
        tick(1);
        bit_boundary = 1'b0;
        chk("apply_pulse",  {15'd0, cfg_applied}, 16'd1);
        chk("apply_nopend", {15'd0, cfg_pending}, 16'd0);
        tick(1);
        chk("apply_one_cycle", {15'd0, cfg_applied}, 16'd0);
        tick(2);
        chk("gain_old_sample", out_data, 16'hC000);
        tick(1);
        chk("gain_half", out_data, 16'hA000);

        // positive DC offset
        in_data = 16'h8000;
        commit(16'h8000, 16'h1000, "commit_offset");
        tick(3);
        chk("offset_data", out_data, 16'h9000);

        // negative saturation and counting
        in_data = 16'h0000;
        commit(16'h8000, 16'h8000, "commit_negsat");
        tick(3);
        chk("negsat_data",   out_data,           16'h0000);
        chk("negsat_flag",   {15'd0, sat_flag},  16'd1);
        chk("negsat_count1", sat_count,          16'd1);
        tick(2);
        chk("negsat_count3", sat_count, 16'd3);

        // clear coinciding with a saturation keeps flag=1, count=1
        sat_clr = 1'b1;
        tick(1);
        sat_clr = 1'b0;
        chk("clr_same_flag",  {15'd0, sat_flag}, 16'd1);
        chk("clr_same_count", sat_count,         16'd1);
        in_data = 16'h8000;
        tick(3);
        sat_clr = 1'b1;
        tick(1);
        sat_clr = 1'b0;
        chk("clr_flag",      {15'd0, sat_flag}, 16'd0);
        chk("clr_count",     sat_count,         16'd0);
        chk("edge_min_data", out_data,          16'h0000);

        // positive saturation
        in_data = 16'hFFFF;
        commit(16'hFFFF, 16'h0000, "commit_possat");
        tick(3);
        chk("possat_data",  out_data,          16'hFFFF);
        chk("possat_flag",  {15'd0, sat_flag}, 16'd1);
        chk("possat_count", sat_count,         16'd1);

        // timeout commit after 16 cycles with no boundary
        cfg_amp    = 16'h8000;
        cfg_offset = 16'h0000;
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        tick(15);
        chk("tmo_early_applied", {15'd0, cfg_applied}, 16'd0);
        chk("tmo_early_pending", {15'd0, cfg_pending}, 16'd1);
        tick(1);
        chk("tmo_applied", {15'd0, cfg_applied}, 16'd1);
        tick(1);

        // re-update at cycle 10 restarts the timeout
        in_data    = 16'hC000;
        cfg_amp    = 16'h4000;
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        tick(9);
        cfg_amp    = 16'h2000;
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        chk("reupd_pending", {15'd0, cfg_pending}, 16'd1);
        tick(15);
        chk("reupd_early_applied", {15'd0, cfg_applied}, 16'd0);
        tick(1);
        chk("reupd_applied", {15'd0, cfg_applied}, 16'd1);
        tick(4);
        chk("reupd_second_value", out_data, 16'h9000);

        // rounding of a one-LSB excursion at half gain, then forced midscale
        in_data = 16'h8001;
        commit(16'h4000, 16'h0000, "commit_round");
        tick(3);
        chk("round_data", out_data, ROUND_EXP);
        out_en = 1'b0;
        tick(1);
        chk("out_en_midscale", out_data, 16'h8000);

        // idle input: out_valid drops, data holds
        in_valid = 1'b0;
        out_en   = 1'b1;
        tick(3);
        chk("idle_valid", {15'd0, out_valid}, 16'd0);
        chk("idle_hold",  out_data,           ROUND_EXP);

        // reset mid-operation discards pending config
        cfg_amp    = 16'h1234;
        cfg_update = 1'b1;
        tick(1);
        cfg_update = 1'b0;
        chk("mid_pending", {15'd0, cfg_pending}, 16'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_pending", {15'd0, cfg_pending}, 16'd0);
        chk("mid_rst_flag",    {15'd0, sat_flag},    16'd0);
        chk("mid_rst_count",   sat_count,            16'd0);
        chk("mid_rst_data",    out_data,             16'h8000);
        in_valid = 1'b1;
        in_data  = 16'hC000;
        tick(3);
        chk("mid_rst_unity", out_data, 16'hC000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
